hilo_muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the HI/LO special registers in the 5-stage MIPS pipeline, sitting beside the EX stage.
- Accepts multu/divu commands from EX and runs a 32-iteration shift-add multiply or restoring divide.
- Holds the HI/LO results and serves mfhi/mflo reads.
- Asserts stall toward the pipeline whenever a new command or a HI/LO read arrives while an operation is in flight.

---
 rtl/hilo_muldiv_ctrl.sv | 130 +++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer beside EX: multu/divu over 32 iterations.
// Ports: start/op/opa/opb command, rd_req/rd_sel/rd_data read, busy/stall/done/dz status, hi/lo regs.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             rd_req,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_t;

  state_t state, state_nx;

  // acc: upper product half (+carry) or remainder
  // quo: multiplier / quotient, dvs: multiplicand / divisor
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   sh_rem;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] quo_nx;
  logic             last;
  logic             dz_cmd;

  assign busy    = (state != IDLE);
  assign stall   = busy & (start | rd_req);
  assign rd_data = rd_sel ? hi : lo;
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign dz_cmd  = start & op & (opb == '0);

  always_comb begin
    mul_sum = acc + (quo[0] ? {1'b0, dvs} : '0);
    sh_rem  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    // extra top bit so the sign of the trial is exact
    trial   = {1'b0, sh_rem} - {2'b00, dvs};
    acc_nx  = acc;
    quo_nx  = quo;
    unique case (state)
      MUL: {acc_nx, quo_nx} = {mul_sum, quo} >> 1;
      DIV: begin
        if (!trial[WIDTH+1]) begin
          acc_nx = trial[WIDTH:0];
          quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
          acc_nx = sh_rem;
          quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start && !dz_cmd) state_nx = op ? DIV : MUL;
      MUL,
      DIV:     if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      dz   <= 1'b0;
    end else begin
      done <= 1'b0;
      dz   <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          if (dz_cmd) begin
            hi   <= opa;
            lo   <= '1;
            done <= 1'b1;
            dz   <= 1'b1;
          end else begin
            acc <= '0;
            quo <= op ? opa : opb;
            dvs <= op ? opb : opa;
            cnt <= '0;
          end
        end
      end else begin
        acc <= acc_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi   <= acc_nx[WIDTH-1:0];
          lo   <= quo_nx;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: results checked on done,
// reads checked on unstalled rd_req.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .opa(opa), .opb(opb), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done),
    .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        resq[$];
  logic [31:0] rdq[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // result monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      n_cmp++;
      if (resq.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got hi=%h lo=%h dz=%b want none",
                 hi, lo, dz);
      end else begin
        exp_t e;
        e = resq.pop_front();
        if (hi !== e.hi || lo !== e.lo || dz !== e.dz) begin
          n_bad++;
          $display("FAIL result: got hi=%h lo=%h dz=%b want hi=%h lo=%h dz=%b",
                   hi, lo, dz, e.hi, e.lo, e.dz);
        end
      end
    end
  end

  // read monitor
  always @(negedge clk) begin
    if (!rst && rd_req && !stall && rdq.size() > 0) begin
      logic [31:0] r;
      r = rdq.pop_front();
      n_cmp++;
      if (rd_data !== r) begin
        n_bad++;
        $display("FAIL rd_data: got %h want %h", rd_data, r);
      end
    end
  end

  task automatic push_res(input logic [31:0] h, input logic [31:0] l,
                          input logic d);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.dz = d;
    resq.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int want);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk(name, 64'(n), 64'(want));
  endtask

  task automatic run_op(input logic o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input logic ed);
    push_res(eh, el, ed);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (ed) begin
      chk("dz_no_busy", 64'(busy), 64'(0));
      @(negedge clk);
    end else begin
      wait_idle("busy_len", 32);
    end
  endtask

  task automatic rd(input logic s, input logic [31:0] e);
    @(posedge clk);
    #1;
    rd_req = 1'b1;
    rd_sel = s;
    rdq.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int nd;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    opa    = '0;
    opb    = '0;
    rd_req = 1'b0;
    rd_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_flags", {60'd0, busy, done, dz, stall}, 64'd0);

    run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    rd(1'b0, 32'd42);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    rd(1'b1, 32'hFFFF_FFFE);
    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op(1'b1, 32'd5, 32'd9, 32'd5, 32'd0, 1'b0);
    run_op(1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    rd(1'b0, 32'hFFFF_FFFF);

    // stall: read and second start during busy
    push_res(32'd0, 32'h200, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 1'b0;
    opa   = 32'h10;
    opb   = 32'h20;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rd_req = 1'b1;
    rd_sel = 1'b0;
    rdq.push_back(32'h200);
    start = 1'b1;
    op    = 1'b1;
    opa   = 32'd100;
    opb   = 32'd7;
    push_res(32'd2, 32'd14, 1'b0);
    @(negedge clk);
    chk("stall_on", 64'(stall), 64'(1));
    n = 0;
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_len", 64'(n), 64'(28));
    @(posedge clk);
    #1;
    start  = 1'b0;
    rd_req = 1'b0;
    chk("second_accept", 64'(busy), 64'(1));
    wait_idle("busy_len2", 32);

    // reset mid-divide
    run_op(1'b1, 32'd23, 32'd5, 32'd3, 32'd4, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = 1'b1;
    opa   = 32'd100;
    opb   = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hilo", {hi, lo}, 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'(0));
    run_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

    repeat (3) @(posedge clk);
    chk("res_queue_empty", 64'(resq.size()), 64'(0));
    chk("rd_queue_empty", 64'(rdq.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
